dct_loader: RTL and testbench
=============================

Name: dct_loader

Overview:
- Upstream feeder for the Avalon DCT slave (avalon_dct). Accepts a stream of fixed-point samples on a valid/ready interface and buffers them in a small FIFO.
- Issues the slave's load sequence as an Avalon-MM write master: fixed-point integer-bit count to address 2, log2 of the frame size to address 0, then 2^log2n samples to address 1.
- Sits between the sample source (sensor / cos unit / software FIFO) and the DCT slave. Frees the source from cycle-exact write timing.

Parameters:
- NBITS, 16, sample and writedata width.
- MAX_LOG2, 6, largest supported log2 frame size (64 samples).
- FIFO_DEPTH, 4, sample buffer entries; power of two, at least 2.

Ports:
- Clock  in  1  system clock; all logic on the rising edge.
- ResetN  in  1  asynchronous active-low reset.
- cfg_start  in  1  one-cycle pulse; latches cfg_m and cfg_log2n and begins a frame.
- cfg_m  in  5  integer bits M of the slave's fixed-point format (0..NBITS-1).
- cfg_log2n  in  4  log2 of the frame size.
- s_valid  in  1  source sample valid.
- s_data  in  NBITS  source sample.
- s_ready  out  1  loader accepts s_data this cycle.
- addr  out  8  Avalon address.
- write  out  1  Avalon write strobe.
- writedata  out  NBITS  Avalon write data.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when the last sample write has been issued.

Behaviour:
- Reset, asynchronous, while ResetN=0:
  - addr=0, write=0, writedata=0, busy=0, done=0, s_ready=0.
  - FIFO emptied; counters cleared; FSM in IDLE.
  - Reset mid-frame abandons the frame; no further writes are issued.
- All Avalon outputs are registered. The slave accepts one write per cycle with no waitrequest. Gaps (write=0) between sample writes are legal; addr stays at 1 during gaps.
- FSM states: IDLE, WR_M, WR_SIZE, STREAM, FIN.
  - IDLE: busy=0. On cfg_start, latch M=cfg_m and L=min(cfg_log2n, MAX_LOG2), clear both counters, go to WR_M. Any cfg_start outside IDLE is ignored.
  - WR_M: drive addr=2, write=1, writedata=M zero-extended, for exactly one cycle. Go to WR_SIZE.
  - WR_SIZE: drive addr=0, write=1, writedata=L zero-extended (the exponent, not 2^L), for one cycle. Go to STREAM.
  - STREAM: addr=1. When the FIFO is non-empty, pop one entry: write=1, writedata=entry, wr_cnt++. Otherwise write=0. When wr_cnt reaches 2^L after a pop, go to FIN.
  - FIN: write=0, addr=0, done=1 for one cycle, busy=0 next cycle. Go to IDLE.
- busy=1 in WR_M, WR_SIZE, STREAM and FIN.
- Cycle timing: cfg_start sampled at edge 0 gives the M write visible after edge 1 and the size write after edge 2. With a pre-filled FIFO, the first sample write is visible after edge 3 and the last after edge 2+2^L. done is visible after the following edge.
- Sample intake:
  - s_ready = busy && !fifo_full && (acc_cnt < 2^L).
  - Handshake is s_valid && s_ready. acc_cnt increments on each handshake.
  - Samples may be accepted from WR_M onward, so the FIFO pre-fills during the header writes.
  - Excess samples beyond 2^L are never accepted.
- FIFO:
  - Push and pop in the same cycle are legal, including when full; occupancy is unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - An occupancy counter distinguishes full from empty.
- Counter widths are MAX_LOG2+1 bits so that 2^MAX_LOG2 is representable.
- cfg_log2n=0 gives a frame of one sample.

Optional Feature:
- Macro DCT_LOADER_REFORMAT_EN.
- Without it: samples are written unchanged.
- With it: source samples are Q0.(NBITS-1) (sign plus fraction) and are converted to the slave's format with M integer bits:
  - Arithmetic right shift by M, rounding half up (add bit M-1 before the shift when M>0).
  - Result saturates at +max of NBITS signed.
  - M=0 passes through unchanged.
  - The conversion is applied at FIFO output, is combinational into the writedata register, and adds no latency.

Test Plan:
- Reset: hold ResetN=0 with s_valid=1 and cfg_start=1 -> write=0, addr=0, s_ready=0, busy=0, done=0.
- Basic frame: cfg_m=6, cfg_log2n=2, samples 0x0040, 0x0030, 0x0020, 0x0010 offered back-to-back -> write trace (2,6), (0,2), (1,0x0040), (1,0x0030), (1,0x0020), (1,0x0010) on consecutive cycles; done pulses exactly once on the next cycle.
- Source gaps: log2n=2, s_valid toggling 1,0,0,1,1,0,1 -> exactly 4 writes at addr 1 in order, write=0 during gaps, addr held at 1.
- Backpressure and overrun: FIFO_DEPTH=4, log2n=3, source offers 10 samples while the FIFO fills during the header writes -> s_ready drops when full and after 8 acceptances; exactly 8 sample writes; samples 9 and 10 remain unconsumed.
- Clamp and ignore: cfg_log2n=9 -> size write carries 6 and 64 sample writes follow; a cfg_start mid-STREAM is ignored. ResetN pulsed low mid-STREAM -> writes stop immediately and a fresh frame afterwards starts with the M write.
- REFORMAT_EN, M=6: input 0x7FFF -> 0x0200; 0x8000 -> 0xFE00; 0x0020 -> 0x0001 (0.5 LSB rounds up).

Source files
------------

// File: rtl/dct_loader.sv
// Sample FIFO plus Avalon-MM write master that loads the DCT slave.
// Optional Q0.(NBITS-1) to QM conversion: DCT_LOADER_REFORMAT_EN.
module dct_loader #(
    parameter int NBITS      = 16,
    parameter int MAX_LOG2   = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             cfg_start,
    input  logic [4:0]       cfg_m,
    input  logic [3:0]       cfg_log2n,
    input  logic             s_valid,
    input  logic [NBITS-1:0] s_data,
    output logic             s_ready,
    output logic [7:0]       addr,
    output logic             write,
    output logic [NBITS-1:0] writedata,
    output logic             busy,
    output logic             done
);
    localparam int CW = MAX_LOG2 + 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, WR_M, WR_SIZE, STREAM, FIN
    } state_t;

    state_t           state, state_nxt;
    logic [4:0]       m_q;
    logic [3:0]       l_q;
    logic [3:0]       l_in;
    logic [CW-1:0]    frame_len;
    logic [CW-1:0]    acc_cnt;
    logic [CW-1:0]    wr_cnt;

    logic [NBITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [AW:0]      occ;
    logic             fifo_full, fifo_empty;
    logic             push, pop, last;
    logic [NBITS-1:0] head, conv;

    logic [7:0]       addr_d;
    logic             write_d, done_d;
    logic [NBITS-1:0] wdata_d;

    assign l_in       = (cfg_log2n > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : cfg_log2n;
    assign frame_len  = CW'(1) << l_q;
    assign fifo_full  = (occ == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (occ == '0);
    assign busy       = (state != IDLE);
    assign s_ready    = busy && !fifo_full && (acc_cnt < frame_len);
    assign push       = s_valid && s_ready;
    assign pop        = (state == STREAM) && !fifo_empty;
    assign last       = pop && ((wr_cnt + CW'(1)) == frame_len);
    assign head       = mem[rd_ptr];

`ifdef DCT_LOADER_REFORMAT_EN
    localparam logic signed [NBITS:0] POS_MAX = {2'b00, {(NBITS-1){1'b1}}};
    logic signed [NBITS:0] ext, rnd, sum, shifted;

    // Round half up by adding bit M-1 ahead of the arithmetic shift
    always_comb begin
        ext     = {head[NBITS-1], head};
        rnd     = (m_q != 5'd0) ? ((NBITS+1)'(1) <<< (m_q - 5'd1)) : '0;
        sum     = ext + rnd;
        shifted = sum >>> m_q;
        conv    = (shifted > POS_MAX) ? POS_MAX[NBITS-1:0]
                                      : shifted[NBITS-1:0];
    end
`else
    assign conv = head;
`endif

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (cfg_start) state_nxt = WR_M;
            WR_M:    state_nxt = WR_SIZE;
            WR_SIZE: state_nxt = STREAM;
            STREAM:  if (last) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        addr_d  = 8'd0;
        write_d = 1'b0;
        wdata_d = writedata;
        done_d  = 1'b0;
        unique case (state)
            WR_M: begin
                addr_d  = 8'd2;
                write_d = 1'b1;
                wdata_d = NBITS'(m_q);
            end
            WR_SIZE: begin
                addr_d  = 8'd0;
                write_d = 1'b1;
                wdata_d = NBITS'(l_q);
            end
            STREAM: begin
                addr_d  = 8'd1;
                write_d = pop;
                if (pop) wdata_d = conv;
            end
            FIN:     done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            addr      <= '0;
            write     <= 1'b0;
            writedata <= '0;
            done      <= 1'b0;
        end else begin
            addr      <= addr_d;
            write     <= write_d;
            writedata <= wdata_d;
            done      <= done_d;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            m_q     <= '0;
            l_q     <= '0;
            acc_cnt <= '0;
            wr_cnt  <= '0;
        end else if (state == IDLE) begin
            if (cfg_start) begin
                m_q     <= cfg_m;
                l_q     <= l_in;
                acc_cnt <= '0;
                wr_cnt  <= '0;
            end
        end else begin
            if (push) acc_cnt <= acc_cnt + CW'(1);
            if (pop)  wr_cnt  <= wr_cnt + CW'(1);
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (push) mem[wr_ptr] <= s_data;
    end

endmodule

// File: tb/tb_dct_loader.sv
// Directed bench for dct_loader: header writes, streaming, gaps,
// overrun, clamp, ignored restart and mid-frame reset.
module tb_dct_loader;
    logic        Clock = 1'b0;
    logic        ResetN = 1'b0;
    logic        cfg_start = 1'b0;
    logic [4:0]  cfg_m = '0;
    logic [3:0]  cfg_log2n = '0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_ready;
    logic [7:0]  addr;
    logic        write;
    logic [15:0] writedata;
    logic        busy;
    logic        done;

    dct_loader #(.NBITS(16), .MAX_LOG2(6), .FIFO_DEPTH(4)) dut (
        .Clock(Clock), .ResetN(ResetN), .cfg_start(cfg_start),
        .cfg_m(cfg_m), .cfg_log2n(cfg_log2n), .s_valid(s_valid),
        .s_data(s_data), .s_ready(s_ready), .addr(addr), .write(write),
        .writedata(writedata), .busy(busy), .done(done)
    );

    always #5 Clock = ~Clock;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    logic [23:0] wlog[$];
    int          wcyc[$];
    int          done_cnt, done_cyc, gap_cnt, bad_gap;
    bit          in_stream;
    logic [15:0] src [80];

    // Write/done monitor, sampled mid-cycle
    always @(negedge Clock) begin
        if (!ResetN) in_stream = 1'b0;
        if (write) begin
            wlog.push_back({addr, writedata});
            wcyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            in_stream = 1'b0;
        end else if (in_stream && !write) begin
            gap_cnt++;
            if (addr != 8'd1) bad_gap++;
        end
        if (write && addr == 8'd0) in_stream = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wlog.delete();
        wcyc.delete();
        done_cnt = 0;
        done_cyc = -1;
        gap_cnt = 0;
        bad_gap = 0;
    endtask

    function automatic logic [23:0] wr_at(input int i);
        if (i < wlog.size()) return wlog[i];
        return 24'hxxxxxx;
    endfunction

    task automatic run(input logic [4:0] m, input logic [3:0] ln,
                       input int nsrc, input logic [31:0] vpat,
                       input int vlen, input int ncyc,
                       input int pulse_at, output int acc);
        acc = 0;
        cfg_m = m;
        cfg_log2n = ln;
        cfg_start = 1'b1;
        s_valid = 1'b0;
        @(posedge Clock); #1;
        cfg_start = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            cfg_start = (c == pulse_at);
            if (c == pulse_at) begin
                cfg_m = 5'd9;
                cfg_log2n = 4'd1;
            end
            s_valid = (acc < nsrc) && (c >= vlen || vpat[c]);
            s_data = (acc < nsrc) ? src[acc] : 16'h0;
            #1;
            if (s_valid && s_ready) acc++;
            @(posedge Clock); #1;
        end
        cfg_start = 1'b0;
        s_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, bad, n2;
        logic [23:0] exp6 [6];
        logic [15:0] e0, e1, e2, e3, e4;

        // Reset with hostile inputs
        s_valid = 1'b1;
        cfg_start = 1'b1;
        cfg_log2n = 4'd2;
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_write", write, 1'b0);
        chk("rst_addr", addr, 8'd0);
        chk("rst_wdata", writedata, 16'h0);
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        s_valid = 1'b0;
        cfg_start = 1'b0;
        ResetN = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        clear_log();

        // Basic frame, M=6, 4 samples back-to-back
`ifdef DCT_LOADER_REFORMAT_EN
        e0 = 16'h0001; e1 = 16'h0001; e2 = 16'h0001; e3 = 16'h0000;
`else
        e0 = 16'h0040; e1 = 16'h0030; e2 = 16'h0020; e3 = 16'h0010;
`endif
        src[0] = 16'h0040; src[1] = 16'h0030;
        src[2] = 16'h0020; src[3] = 16'h0010;
        run(5'd6, 4'd2, 4, 32'hFFFF_FFFF, 0, 12, -1, acc);
        exp6[0] = {8'd2, 16'd6};
        exp6[1] = {8'd0, 16'd2};
        exp6[2] = {8'd1, e0};
        exp6[3] = {8'd1, e1};
        exp6[4] = {8'd1, e2};
        exp6[5] = {8'd1, e3};
        chk("basic_nwr", wlog.size(), 6);
        chk("basic_acc", acc, 4);
        for (int i = 0; i < 6; i++) chk($sformatf("basic_wr%0d", i), wr_at(i), exp6[i]);
        bad = 0;
        for (int i = 1; i < wcyc.size(); i++) if (wcyc[i] != wcyc[i-1] + 1) bad++;
        chk("basic_consec", bad, 0);
        chk("basic_done_cnt", done_cnt, 1);
        chk("basic_done_cyc", done_cyc, (wcyc.size() == 6) ? wcyc[5] + 1 : -2);
        chk("basic_busy_end", busy, 1'b0);
        clear_log();

        // Source gaps: valid 1,0,0,1,1,0,1
        src[0] = 16'h00A1; src[1] = 16'h00A2;
        src[2] = 16'h00A3; src[3] = 16'h00A4;
        run(5'd0, 4'd2, 4, 32'h0000_0059, 7, 16, -1, acc);
        chk("gap_nwr", wlog.size(), 6);
        for (int i = 0; i < 4; i++) chk($sformatf("gap_wr%0d", i), wr_at(i+2), {8'd1, src[i]});
        chk("gap_idle_cycles", gap_cnt, 2);
        chk("gap_addr_held", bad_gap, 0);
        chk("gap_done_cnt", done_cnt, 1);
        clear_log();

        // Overrun: 10 offered, 8-sample frame
        for (int i = 0; i < 10; i++) src[i] = 16'h0B00 + 16'(i);
        run(5'd0, 4'd3, 10, 32'hFFFF_FFFF, 0, 20, -1, acc);
        chk("ovr_acc", acc, 8);
        chk("ovr_nwr", wlog.size(), 10);
        n2 = 0;
        for (int i = 0; i < wlog.size(); i++) if (wlog[i][23:16] == 8'd1) n2++;
        chk("ovr_nsample", n2, 8);
        chk("ovr_last", wr_at(9), {8'd1, 16'h0B07});
        chk("ovr_s_ready", s_ready, 1'b0);
        chk("ovr_done_cnt", done_cnt, 1);
        clear_log();

        // Clamp log2n=9 to 6 and ignore cfg_start mid-stream
        for (int i = 0; i < 64; i++) src[i] = 16'h0100 + 16'(i);
        run(5'd0, 4'd9, 64, 32'hFFFF_FFFF, 0, 80, 20, acc);
        chk("clamp_nwr", wlog.size(), 66);
        chk("clamp_m", wr_at(0), {8'd2, 16'd0});
        chk("clamp_size", wr_at(1), {8'd0, 16'd6});
        bad = 0;
        n2 = 0;
        for (int i = 2; i < wlog.size(); i++) begin
            if (wlog[i] != {8'd1, src[i-2]}) bad++;
        end
        for (int i = 0; i < wlog.size(); i++) if (wlog[i][23:16] == 8'd2) n2++;
        chk("clamp_order", bad, 0);
        chk("clamp_one_hdr", n2, 1);
        chk("clamp_done_cnt", done_cnt, 1);
        clear_log();

        // Reset mid-stream, then a fresh one-sample frame
        for (int i = 0; i < 8; i++) src[i] = 16'h0C00 + 16'(i);
        run(5'd3, 4'd3, 8, 32'hFFFF_FFFF, 0, 4, -1, acc);
        chk("mid_wrote", wlog.size() > 2, 1'b1);
        ResetN = 1'b0;
        #1;
        chk("mid_rst_write", write, 1'b0);
        chk("mid_rst_addr", addr, 8'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_s_ready", s_ready, 1'b0);
        clear_log();
        repeat (2) @(posedge Clock);
        #1;
        ResetN = 1'b1;
        repeat (4) @(posedge Clock);
        #1;
        chk("mid_no_writes", wlog.size(), 0);
        chk("mid_no_done", done_cnt, 0);
`ifdef DCT_LOADER_REFORMAT_EN
        e4 = 16'h0020;
`else
        e4 = 16'h0400;
`endif
        src[0] = 16'h0400;
        run(5'd5, 4'd0, 1, 32'hFFFF_FFFF, 0, 8, -1, acc);
        chk("fresh_nwr", wlog.size(), 3);
        chk("fresh_m", wr_at(0), {8'd2, 16'd5});
        chk("fresh_size", wr_at(1), {8'd0, 16'd0});
        chk("fresh_sample", wr_at(2), {8'd1, e4});
        chk("fresh_done_cnt", done_cnt, 1);
        clear_log();

`ifdef DCT_LOADER_REFORMAT_EN
        // Conversion to M=6 with rounding
        src[0] = 16'h7FFF; src[1] = 16'h8000;
        src[2] = 16'h0020; src[3] = 16'h0010;
        run(5'd6, 4'd2, 4, 32'hFFFF_FFFF, 0, 12, -1, acc);
        chk("fmt_nwr", wlog.size(), 6);
        chk("fmt_max", wr_at(2), {8'd1, 16'h0200});
        chk("fmt_min", wr_at(3), {8'd1, 16'hFE00});
        chk("fmt_half", wr_at(4), {8'd1, 16'h0001});
        chk("fmt_quarter", wr_at(5), {8'd1, 16'h0000});
        clear_log();
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
